// File: rtl/scancode_event_fifo_if.sv
// Scan-code input / key-event output bundle for scancode_event_fifo.
// The slave modport is the decoder side; the master modport is the producer/consumer side.
interface scancode_event_fifo_if #(
    parameter int FIFO_AW = 2
);
    logic               valid_scan_code;
    logic [7:0]         scan_code_in;
    logic               ev_ready;
    logic               ovf_clr;
    logic               ev_valid;
    logic [7:0]         ev_code;
    logic               ev_ext;
    logic               ev_release;
    logic [FIFO_AW:0]   fifo_count;
    logic               overflow;

    modport master (
        output valid_scan_code, scan_code_in, ev_ready, ovf_clr,
        input  ev_valid, ev_code, ev_ext, ev_release, fifo_count, overflow
    );

    modport slave (
        input  valid_scan_code, scan_code_in, ev_ready, ovf_clr,
        output ev_valid, ev_code, ev_ext, ev_release, fifo_count, overflow
    );
endinterface

// File: rtl/scancode_event_fifo.sv
// PS/2 set-2 prefix decoder (E0/F0) feeding a small key-event FIFO drained over valid/ready.
// Optional macro REPEAT_FILTER_EN suppresses typematic repeats of the currently held key.
module scancode_event_fifo #(
    parameter int FIFO_AW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    scancode_event_fifo_if.slave bus
);
    localparam int               DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [7:0]       CODE_EXT   = 8'hE0;
    localparam logic [7:0]       CODE_BRK   = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    state_t             r_state;
    logic               r_valid_d;
    logic [9:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [9:0]         r_head;
    logic               r_overflow;

    logic               w_accept;
    logic               w_is_ext;
    logic               w_is_brk;
    logic               w_emit;
    logic [9:0]         w_event;
    logic               w_suppress;
    logic               w_write;
    logic               w_full;
    logic               w_pop;
    logic               w_do_write;
    logic               w_drop;
    logic [FIFO_AW-1:0] w_rptr_next;
    logic [FIFO_AW:0]   w_count_next;
    logic [9:0]         w_head_next;

    // Only the rising edge of valid_scan_code takes a byte, so a long strobe yields one accept.
    assign w_accept = bus.valid_scan_code & ~r_valid_d;
    assign w_is_ext = (bus.scan_code_in == CODE_EXT);
    assign w_is_brk = (bus.scan_code_in == CODE_BRK);
    assign w_emit   = w_accept & ~w_is_ext & ~w_is_brk;
    assign w_event  = {(r_state == ST_BRK) || (r_state == ST_EXT_BRK),
                       (r_state == ST_EXT) || (r_state == ST_EXT_BRK),
                       bus.scan_code_in};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid_d <= 1'b1;
            r_state   <= ST_IDLE;
        end else begin
            r_valid_d <= bus.valid_scan_code;
            if (w_accept) begin
                if (w_is_ext) begin
                    r_state <= ST_EXT;
                end else if (w_is_brk) begin
                    case (r_state)
                        ST_EXT, ST_EXT_BRK: r_state <= ST_EXT_BRK;
                        default:            r_state <= ST_BRK;
                    endcase
                end else begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

`ifdef REPEAT_FILTER_EN
    logic [8:0] r_held_key;
    logic       r_held_vld;

    assign w_suppress = w_emit & ~w_event[9] & r_held_vld & (r_held_key == w_event[8:0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_held_key <= 9'h000;
            r_held_vld <= 1'b0;
        end else if (w_emit) begin
            if (!w_event[9]) begin
                if (!w_suppress) begin
                    r_held_key <= w_event[8:0];
                    r_held_vld <= 1'b1;
                end
            end else if (r_held_key == w_event[8:0]) begin
                r_held_vld <= 1'b0;
            end
        end
    end
`else
    assign w_suppress = 1'b0;
`endif

    assign w_write     = w_emit & ~w_suppress;
    assign w_full      = (r_count == FULL_COUNT);
    assign w_pop       = (r_count != '0) & bus.ev_ready;
    assign w_do_write  = w_write & (~w_full | w_pop);
    assign w_drop      = w_write & w_full & ~w_pop;
    assign w_rptr_next = w_pop ? r_rptr + 1'b1 : r_rptr;

    always_comb begin
        w_count_next = r_count;
        if (w_do_write && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_do_write && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // Head register: when the queue drains it keeps the last entry shown instead of stale RAM.
    always_comb begin
        w_head_next = r_head;
        if (w_count_next != '0) begin
            if (w_do_write && (r_wptr == w_rptr_next)) begin
                w_head_next = w_event;
            end else begin
                w_head_next = r_mem[w_rptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_wptr] <= w_event;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_head     <= 10'h000;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_write) begin
                r_wptr <= r_wptr + 1'b1;
            end
            r_rptr  <= w_rptr_next;
            r_count <= w_count_next;
            r_head  <= w_head_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.ev_valid   = (r_count != '0);
    assign bus.ev_release = r_head[9];
    assign bus.ev_ext     = r_head[8];
    assign bus.ev_code    = r_head[7:0];
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_scancode_event_fifo.sv
// Self-checking bench for scancode_event_fifo: directed steps then random traffic,
// compared every cycle against a queue-based model of the prefix decoder and FIFO.
module tb_scancode_event_fifo;
    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic clk;
    logic rst;

    scancode_event_fifo_if #(.FIFO_AW(FIFO_AW)) bus ();

    scancode_event_fifo #(.FIFO_AW(FIFO_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors;
    int unsigned miscompares;

    logic [9:0] mQueue [$];
    logic       mPrevValid;
    logic       mExt;
    logic       mBrk;
    logic       mOvf;
    logic [9:0] mLast;
    logic [8:0] mHeldKey;
    logic       mHeldVld;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge, written from the key-event rules rather than the RTL structure.
    task automatic modelStep(input logic vsc, input logic [7:0] code, input logic rdy,
                             input logic clr, input logic rstn);
        logic       accept;
        logic       pop;
        logic       emit;
        logic       full;
        logic       drop;
        logic [9:0] ev;
        if (!rstn) begin
            mQueue.delete();
            mPrevValid = 1'b1;
            mExt       = 1'b0;
            mBrk       = 1'b0;
            mOvf       = 1'b0;
            mLast      = 10'h000;
            mHeldVld   = 1'b0;
            return;
        end
        accept     = vsc && !mPrevValid;
        mPrevValid = vsc;
        pop        = (mQueue.size() != 0) && rdy;
        full       = (mQueue.size() == DEPTH);
        emit       = 1'b0;
        ev         = 10'h000;
        if (accept) begin
            if (code == 8'hE0) begin
                mExt = 1'b1;
                mBrk = 1'b0;
            end else if (code == 8'hF0) begin
                mBrk = 1'b1;
            end else begin
                ev   = {mBrk, mExt, code};
                emit = 1'b1;
                mExt = 1'b0;
                mBrk = 1'b0;
            end
        end
`ifdef REPEAT_FILTER_EN
        if (emit) begin
            if (!ev[9]) begin
                if (mHeldVld && mHeldKey == ev[8:0]) begin
                    emit = 1'b0;
                end else begin
                    mHeldKey = ev[8:0];
                    mHeldVld = 1'b1;
                end
            end else if (mHeldKey == ev[8:0]) begin
                mHeldVld = 1'b0;
            end
        end
`endif
        drop = emit && full && !pop;
        if (pop) mLast = mQueue.pop_front();
        if (emit && !drop) mQueue.push_back(ev);
        if (drop) mOvf = 1'b1;
        else if (clr) mOvf = 1'b0;
    endtask

    task automatic checkOutput();
        logic [9:0] expHead;
        expHead = (mQueue.size() != 0) ? mQueue[0] : mLast;
        checkValue("ev_valid", 32'(bus.ev_valid), 32'(mQueue.size() != 0));
        checkValue("ev_event", 32'({bus.ev_release, bus.ev_ext, bus.ev_code}), 32'(expHead));
        checkValue("fifo_count", 32'(bus.fifo_count), 32'(mQueue.size()));
        checkValue("overflow", 32'(bus.overflow), 32'(mOvf));
    endtask

    task automatic applyStimulus(input logic vsc, input logic [7:0] code, input logic rdy,
                                 input logic clr, input logic rstn);
        bus.valid_scan_code = vsc;
        bus.scan_code_in    = code;
        bus.ev_ready        = rdy;
        bus.ovf_clr         = clr;
        rst                 = rstn;
        modelStep(vsc, code, rdy, clr, rstn);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic sendByte(input logic [7:0] code, input logic rdy);
        applyStimulus(1'b1, code, rdy, 1'b0, 1'b1);
        applyStimulus(1'b0, code, rdy, 1'b0, 1'b1);
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        logic       vsc;
        logic [7:0] code;
        logic       rstn;
        int         sel;
        vectors             = 0;
        miscompares         = 0;
        rst                 = 1'b0;
        bus.valid_scan_code = 1'b1;
        bus.scan_code_in    = 8'h1C;
        bus.ev_ready        = 1'b0;
        bus.ovf_clr         = 1'b0;

        // Valid held high through reset must not be taken as a byte.
        applyStimulus(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h1C, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h1C, 1'b0, 1'b0, 1'b1);
        checkValue("no_accept_after_rst", 32'(bus.fifo_count), 32'd0);

        applyStimulus(1'b0, 8'h1C, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h1C, 1'b0, 1'b0, 1'b1);
        checkValue("pulse_latency", 32'(bus.ev_valid), 32'd1);
        for (int i = 0; i < 19; i++) applyStimulus(1'b1, 8'h1C, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h1C, 1'b0, 1'b0, 1'b1);
        checkValue("pulse_event", 32'({bus.ev_release, bus.ev_ext, bus.ev_code}), 32'h01C);
        checkValue("pulse_count", 32'(bus.fifo_count), 32'd1);
        drain(2);

        sendByte(8'hF0, 1'b0);
        checkValue("f0_no_event", 32'(bus.fifo_count), 32'd0);
        sendByte(8'h1C, 1'b0);
        checkValue("break_event", 32'({bus.ev_release, bus.ev_ext, bus.ev_code}), 32'h21C);
        drain(2);

        sendByte(8'hE0, 1'b0);
        sendByte(8'hF0, 1'b0);
        sendByte(8'h75, 1'b0);
        checkValue("ext_break_event", 32'({bus.ev_release, bus.ev_ext, bus.ev_code}), 32'h375);
        drain(2);
        sendByte(8'hE0, 1'b0);
        sendByte(8'h75, 1'b0);
        checkValue("ext_make_event", 32'({bus.ev_release, bus.ev_ext, bus.ev_code}), 32'h175);
        drain(2);

        for (int i = 0; i <= DEPTH; i++) sendByte(8'h15 + 8'(i), 1'b0);
        checkValue("full_count", 32'(bus.fifo_count), 32'(DEPTH));
        checkValue("ovf_set", 32'(bus.overflow), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        checkValue("ovf_clr", 32'(bus.overflow), 32'd0);
        applyStimulus(1'b1, 8'h2A, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h2A, 1'b0, 1'b0, 1'b1);
        checkValue("full_rw_count", 32'(bus.fifo_count), 32'(DEPTH));
        checkValue("full_rw_no_ovf", 32'(bus.overflow), 32'd0);
        drain(DEPTH + 2);

        sendByte(8'hE0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        sendByte(8'h75, 1'b0);
        checkValue("prefix_reset", 32'({bus.ev_release, bus.ev_ext, bus.ev_code}), 32'h075);
        drain(2);

        sendByte(8'h1C, 1'b0);
        sendByte(8'h1C, 1'b0);
        sendByte(8'h1C, 1'b0);
        sendByte(8'hF0, 1'b0);
        sendByte(8'h1C, 1'b0);
        sendByte(8'h1C, 1'b0);
`ifdef REPEAT_FILTER_EN
        checkValue("repeat_count", 32'(bus.fifo_count), 32'd3);
`endif
        drain(DEPTH + 2);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        code = 8'h1C;
        for (int i = 0; i < 600; i++) begin
            vsc  = ($urandom_range(0, 1) == 1);
            rstn = ($urandom_range(0, 149) != 0);
            if (!vsc) begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0:       code = 8'hE0;
                    1:       code = 8'hF0;
                    2:       code = 8'h1C;
                    3:       code = 8'h75;
                    default: code = 8'($urandom_range(0, 255));
                endcase
            end
            applyStimulus(vsc, code, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), rstn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
